mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single read port and single write port of the unified memory between two requesters.
- Requester I is instruction fetch and is read-only. Requester D is load/store and can read or write.
- Drives the memory's combinational read address and synchronous write port.
- Returns read data through a registered response with a one-cycle latency.
- Sits between the IF/MEM pipeline stages and the memory. Stall signals are derived from the grant outputs.

Parameters:
- ADDR_W, default `ADDR_WIDTH: address width.
- DATA_W, default `DATA_WIDTH: data width.
- STARVE_LIMIT, default 3: consecutive I-read denials after which I wins the read port. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch read request.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  combinational; fetch accepted this cycle.
- i_rvalid  out  1  registered; fetch data valid.
- i_rdata  out  DATA_W  registered fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read; ignored when d_req=0.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  combinational; data request accepted this cycle.
- d_rvalid  out  1  registered; load data valid.
- d_rdata  out  DATA_W  registered load data.
- starve_cnt  out  4  debug; current I denial count.
- mem_write_en  out  1  to memory write_en.
- mem_read_address  out  ADDR_W  to memory read_address.
- mem_write_address  out  ADDR_W  to memory write_address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out (combinational read).

Behaviour:
- Reset (async, and also when asserted mid-operation):
  - i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, starve_cnt=0, internal ports latch cleared.
  - A read granted in the cycle reset asserts produces no rvalid.
- Handshake:
  - Requester holds req/addr/wdata stable until gnt=1.
  - gnt is a single-cycle acceptance. The requester may issue a new request in the next cycle; back-to-back grants are allowed.
- Write path:
  - d_req & d_we → d_gnt=1 always, same cycle.
  - mem_write_en=1, mem_write_address=d_addr, mem_data_in=d_wdata. Memory updates at that edge.
  - Writes never conflict with reads; no d_rvalid for writes.
  - When no write is granted: mem_write_en=0, mem_write_address=d_addr, mem_data_in=d_wdata (don't-care values, kept deterministic).
- Read port conflict occurs only when I read and D read are requested together (d_req & ~d_we & i_req). Resolution:
  - starve_cnt < STARVE_LIMIT: D wins; I denied.
  - starve_cnt == STARVE_LIMIT: I wins; D denied.
- Uncontested read: the sole read requester is granted.
- D write + I read in the same cycle: both granted.
- mem_read_address selection:
  - Address of the granted reader.
  - With no reader, i_addr (idle default).
- Read latency:
  - In the grant cycle, mem_data_out (async read) is captured at posedge into the winner's rdata.
  - Winner's rvalid=1 for exactly the next cycle. A non-granted port's rvalid=0 and its rdata holds.
- Read-during-write to the same address in the same cycle (I read, D write): I receives the OLD value, since the read is sampled at the same edge the write lands. D read after a D write is in order across cycles.
- Starvation counter:
  - Increments when i_req=1 and i_gnt=0.
  - Clears when i_gnt=1 or i_req=0.
  - Saturates at STARVE_LIMIT.
- Stall contract: upstream stalls IF while i_req & ~i_gnt, and MEM while d_req & ~d_gnt.

Test Plan:
- Reset mid-read: i_req, i_addr=0x010 granted, then reset asserted before the edge → i_rvalid stays 0; all outputs 0; starve_cnt=0.
- Uncontested fetch: mem[0x020]=0xBEEF, i_req, i_addr=0x020 → i_gnt=1 same cycle; next cycle i_rvalid=1, i_rdata=0xBEEF, d_rvalid=0.
- Contention with D priority: i_req@0x001 and d_req read@0x002, both held → D granted 3 cycles with starve_cnt 1,2,3; 4th cycle i_gnt=1, d_gnt=0; starve_cnt→0; D granted again the following cycle.
- Parallel write + fetch, same address: mem[0x030]=0x1111; d write 0x2222@0x030 and i read@0x030 in the same cycle → both gnt=1; next cycle i_rdata=0x1111; subsequent D read of 0x030 returns 0x2222.
- Back-to-back loads: D reads 0x040, 0x041, 0x042 on consecutive cycles with no I request → d_gnt high 3 cycles; d_rvalid high 3 cycles, lagging by one, with data in order.
- Idle: no requests → gnt=0, rvalid=0, mem_write_en=0, starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one combinational read port and one write port between fetch (I) and load/store (D).
// D wins read contention until I has been denied STARVE_LIMIT times in a row.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
module mem_port_arbiter #(
  parameter int ADDR_W       = `ADDR_WIDTH,
  parameter int DATA_W       = `DATA_WIDTH,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [3:0]        starve_cnt,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);
  logic              w_d_rd;
  logic              w_i_win;
  logic              w_d_rd_gnt;
  logic              r_i_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [3:0]        r_starve;
  always_comb begin
    w_d_rd     = d_req & ~d_we;
    w_i_win    = r_starve == 4'(STARVE_LIMIT);
    i_gnt      = i_req & (~w_d_rd | w_i_win);
    d_gnt      = d_req & (d_we | ~i_req | ~w_i_win);
    w_d_rd_gnt = d_gnt & ~d_we;
  end
  assign mem_write_en      = d_req & d_we;
  assign mem_write_address = d_addr;
  assign mem_data_in       = d_wdata;
  assign mem_read_address  = w_d_rd_gnt ? d_addr : i_addr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_starve   <= '0;
    end else begin
      r_i_rvalid <= i_gnt;
      r_d_rvalid <= w_d_rd_gnt;
      if (i_gnt) r_i_rdata <= mem_data_out;
      if (w_d_rd_gnt) r_d_rdata <= mem_data_out;
      r_starve   <= (i_req & ~i_gnt) ? (w_i_win ? r_starve : r_starve + 4'd1) : 4'd0;
    end
  end
  assign i_rvalid   = r_i_rvalid;
  assign i_rdata    = r_i_rdata;
  assign d_rvalid   = r_d_rvalid;
  assign d_rdata    = r_d_rdata;
  assign starve_cnt = r_starve;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a rule-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 10, DW = 16, LIM = 3;
  logic clk = 1'b0, reset;
  logic i_req, d_req, d_we, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_write_en;
  logic [AW-1:0] i_addr, d_addr, mem_read_address, mem_write_address;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, mem_data_in, mem_data_out;
  logic [3:0] starve_cnt;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int n_cmp = 0, n_bad = 0;
  int exp_starve;
  bit exp_iv, exp_dv;
  logic [DW-1:0] exp_ird, exp_drd;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .starve_cnt(starve_cnt),
    .mem_write_en(mem_write_en), .mem_read_address(mem_read_address),
    .mem_write_address(mem_write_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  assign mem_data_out = mem[mem_read_address];
  always @(posedge clk) if (mem_write_en) mem[mem_write_address] <= mem_data_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic model_reset();
    exp_starve = 0; exp_iv = 0; exp_dv = 0; exp_ird = '0; exp_drd = '0;
  endtask

  // Drive one cycle's requests, check the combinational decision, then the registered results.
  task automatic cyc(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                     input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bit drd, conflict, ig, dg;
    logic [AW-1:0] ra;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #3;
    drd = dr && !dw;
    conflict = ir && drd;
    ig = ir && (!conflict || exp_starve >= LIM);
    dg = dr && (dw || !conflict || exp_starve < LIM);
    ra = (dg && drd) ? da : ia;
    chk("i_gnt", i_gnt, ig);
    chk("d_gnt", d_gnt, dg);
    chk("mem_write_en", mem_write_en, dr && dw);
    chk("mem_write_address", mem_write_address, da);
    chk("mem_data_in", mem_data_in, dd);
    chk("mem_read_address", mem_read_address, ra);
    exp_iv = ig;
    exp_dv = dg && drd;
    if (ig) exp_ird = ref_mem[ia];
    if (dg && drd) exp_drd = ref_mem[da];
    if (dr && dw) ref_mem[da] = dd;
    exp_starve = (ir && !ig) ? ((exp_starve + 1 > LIM) ? LIM : exp_starve + 1) : 0;
    @(posedge clk); #1;
    chk("i_rvalid", i_rvalid, exp_iv);
    chk("i_rdata", i_rdata, exp_ird);
    chk("d_rvalid", d_rvalid, exp_dv);
    chk("d_rdata", d_rdata, exp_drd);
    chk("starve_cnt", starve_cnt, exp_starve);
  endtask

  initial begin
    int seq [5] = '{1, 2, 3, 0, 1};
    reset = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int a = 0; a < (1 << AW); a++) poke(a[AW-1:0], DW'($urandom));
    model_reset();
    @(posedge clk); #1;
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_starve", starve_cnt, 0);
    reset = 1'b0;

    poke(10'h020, 16'hBEEF);
    cyc(1, 10'h020, 0, 0, 0, 0);
    chk("fetch_beef", i_rdata, 16'hBEEF);
    chk("fetch_valid", i_rvalid, 1);

    for (int k = 0; k < 5; k++) begin
      cyc(1, 10'h001, 1, 0, 10'h002, 0);
      chk("starve_seq", starve_cnt, seq[k]);
    end
    cyc(0, 0, 0, 0, 0, 0);

    poke(10'h030, 16'h1111);
    cyc(1, 10'h030, 1, 1, 10'h030, 16'h2222);
    chk("rdw_old", i_rdata, 16'h1111);
    cyc(0, 0, 1, 0, 10'h030, 0);
    chk("raw_new", d_rdata, 16'h2222);

    for (int k = 0; k < 3; k++) poke(10'h040 + 10'(k), 16'hA000 + 16'(k));
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 10'h040 + 10'(k), 0);
      chk("b2b_data", d_rdata, 16'hA000 + 16'(k));
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("idle_rvalid", d_rvalid | i_rvalid, 0);

    // Reset lands while a fetch is being granted: no response must emerge.
    cyc(1, 10'h010, 0, 0, 0, 0);
    i_req = 1; i_addr = 10'h010; d_req = 0;
    #2;
    chk("mid_gnt", i_gnt, 1);
    reset = 1'b1;
    #1;
    chk("mid_async_rvalid", i_rvalid, 0);
    @(posedge clk); #1;
    chk("mid_i_rvalid", i_rvalid, 0);
    chk("mid_i_rdata", i_rdata, 0);
    chk("mid_d_rdata", d_rdata, 0);
    chk("mid_starve", starve_cnt, 0);
    reset = 1'b0;
    i_req = 0;
    model_reset();

    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] ia, da;
      ia = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      da = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      cyc($urandom_range(0, 3) != 0, ia, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, da, DW'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
